// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and single-outstanding instruction fetch with a one-entry output register.
// Ports: clk/resetn (async active-low); ireq_valid/ireq_addr request to instruction memory;
// iresp_valid/iresp_data response; redirect_valid/redirect_pc from later stages;
// stall back-pressure from decode; out_valid/out_instr/out_pc registered to decode.
module fetch_unit #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            ireq_valid,
  output logic [PC_W-1:0] ireq_addr,
  input  logic            iresp_valid,
  input  logic [31:0]     iresp_data,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            stall,
  output logic            out_valid,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc
);
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HOLD} state_t;
  state_t          state_q;
  logic [PC_W-1:0] pc_q, pending_q, out_pc_q, redir_pc;
  logic [31:0]     out_instr_q;
  logic            out_valid_q;
  assign redir_pc   = {redirect_pc[PC_W-1:2], 2'b00};
  assign ireq_valid = state_q == FETCH || state_q == FLUSH;
  assign ireq_addr  = pc_q;
  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_pc     = out_pc_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q     <= IDLE;
      pc_q        <= {PC_RESET[PC_W-1:2], 2'b00};
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          if (redirect_valid) pc_q <= redir_pc;
        end
        FETCH:
          if (redirect_valid) begin
            // a request already answered this cycle can be reissued at once; otherwise it must drain
            if (iresp_valid) pc_q <= redir_pc;
            else begin
              pending_q <= redir_pc;
              state_q   <= FLUSH;
            end
          end else if (iresp_valid) begin
            out_instr_q <= iresp_data;
            out_pc_q    <= pc_q;
            out_valid_q <= 1'b1;
            pc_q        <= pc_q + PC_W'(4);
            state_q     <= HOLD;
          end
        FLUSH:
          if (iresp_valid) begin
            pc_q    <= redirect_valid ? redir_pc : pending_q;
            state_q <= FETCH;
          end else if (redirect_valid) pending_q <= redir_pc;
        HOLD:
          if (redirect_valid) begin
            out_valid_q <= 1'b0;
            pc_q        <= redir_pc;
            state_q     <= FETCH;
          end else if (!stall) begin
            out_valid_q <= 1'b0;
            state_q     <= FETCH;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule
